instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared core definitions for the fetch front end: widths, state encoding
// and the instruction word constants.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned ILEN         = 32;

    localparam logic [ILEN-1:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [ILEN-1:0] FAULT_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and decode; power-of-two depth,
// flush clears occupancy, simultaneous push and pop is allowed when full.
module fetch_fifo #(
    parameter int unsigned WIDTH = 97,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: sequential PC, synchronous instruction memory, prefetch
// buffer to decode, invalid-address fault entries and branch redirects.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter int unsigned     IMEM_DEPTH = 1024,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [ILEN-1:0]               imem_wdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ILEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic                          invAddr
);

    localparam int unsigned     AW       = $clog2(IMEM_DEPTH);
    localparam int unsigned     CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned     EW       = ILEN + XLEN + 1;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH) << 2;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            rd_vld_q, rd_vld_d;
    logic            rd_fault_q, rd_fault_d;
    logic [XLEN-1:0] rd_pc_q, rd_pc_d;
    logic [ILEN-1:0] rd_data_q;
    logic [ILEN-1:0] imem_q [IMEM_DEPTH];

    logic            pc_invalid, issue, push, pop, fifo_valid;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     occ;
    logic [EW-1:0]   fifo_wdata, fifo_rdata;

    assign pc_invalid = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
    // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
    assign occ   = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_vld_q};
    assign issue = (state_q == FETCH) && (occ < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_vld_d   = 1'b0;
        rd_fault_d = rd_fault_q;
        rd_pc_d    = rd_pc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (issue) begin
            rd_vld_d   = 1'b1;
            rd_pc_d    = pc_q;
            rd_fault_d = pc_invalid;
            if (pc_invalid) state_d = HALT;
            else            pc_d    = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_fault_q <= rd_fault_d;
        rd_pc_q    <= rd_pc_d;
    end

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_waddr] <= imem_wdata;
        if (issue && !pc_invalid) rd_data_q <= imem_q[pc_q[AW+1:2]];
    end

    assign push       = rd_vld_q && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign fifo_wdata = {(rd_fault_q ? FAULT_WORD : rd_data_q), rd_pc_q, rd_fault_q};

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign out_valid = fifo_valid;
    assign {out_instr, out_pc, invAddr} = fifo_valid ? fifo_rdata : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic,
// checked against an in-order fetch-stream model of the program.
module tb_instruction_fetch_unit;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned AW         = 10;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam logic [63:0] PC_LIMIT   = 64'(IMEM_DEPTH) * 64'd4;

    logic          clk = 1'b0;
    logic          rst, imem_we, redirect_valid, out_valid, out_ready, invAddr;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata, out_instr;
    logic [63:0]   redirect_pc, out_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .invAddr        (invAddr)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem_m [IMEM_DEPTH];
    logic [63:0] exp_pc = RESET_PC;
    bit          exp_halt = 1'b0;
    logic [63:0] last_pc = '0;
    int          accepted = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pc_bad(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);
    endfunction

    // Program-order model: every accepted entry must be the next one in the stream.
    task automatic consume();
        if (exp_halt) begin
            check("entry_after_halt", 64'(out_valid), 64'd0);
        end else if (pc_bad(exp_pc)) begin
            check("fault_pc", out_pc, exp_pc);
            check("fault_instr", 64'(out_instr), 64'd0);
            check("fault_flag", 64'(invAddr), 64'd1);
            exp_halt = 1'b1;
        end else begin
            check("stream_pc", out_pc, exp_pc);
            check("stream_instr", 64'(out_instr), 64'(mem_m[exp_pc[AW+1:2]]));
            check("stream_inv", 64'(invAddr), 64'd0);
            exp_pc = exp_pc + 64'd4;
        end
        last_pc = out_pc;
        accepted++;
    endtask

    task automatic tick();
        bit          hold_now;
        logic [63:0] hp;
        logic [31:0] hi;
        logic        hv;
        hold_now = (out_valid === 1'b1) && !out_ready && !rst && !redirect_valid;
        hp = out_pc;
        hi = out_instr;
        hv = invAddr;
        if (out_valid === 1'b1 && out_ready && !rst) consume();
        if (redirect_valid) begin
            exp_pc   = redirect_pc;
            exp_halt = 1'b0;
        end
        if (rst) begin
            exp_pc   = RESET_PC;
            exp_halt = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold_now) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_pc", out_pc, hp);
            check("hold_instr", 64'(out_instr), 64'(hi));
            check("hold_inv", 64'(invAddr), 64'(hv));
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [31:0] w;
        rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        @(negedge clk);

        // Program load while held in reset.
        for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
            case (i)
                0:       w = 32'h0123_4567;
                1:       w = 32'h89AB_CDEF;
                2:       w = 32'hFEDC_BA98;
                3:       w = 32'h7654_3210;
                default: w = $urandom;
            endcase
            mem_m[i] = w;
            imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = w;
            tick();
        end
        imem_we = 1'b0;
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_inv", 64'(invAddr), 64'd0);

        // Basic burst and two-cycle latency.
        rst = 1'b0; out_ready = 1'b1;
        check("lat_c0", 64'(out_valid), 64'd0);
        tick();
        check("lat_c1", 64'(out_valid), 64'd0);
        tick();
        check("lat_c2", 64'(out_valid), 64'd1);
        check("first_instr", 64'(out_instr), 64'h0123_4567);
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", 64'(out_valid), 64'd1);
            check("burst_pc", out_pc, 64'(i * 4));
            tick();
        end

        // Back-pressure fills the buffer, then drains in order.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("buffered", 64'(dut.fifo_cnt), 64'(FIFO_DEPTH));
        check("stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Redirect with three buffered entries.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("three_buffered", 64'(dut.fifo_cnt), 64'd3);
        redirect_to(64'h8);
        check("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        wait_valid("redir8", 8);
        check("redir8_pc", out_pc, 64'h8);
        check("redir8_instr", 64'(out_instr), 64'hFEDC_BA98);
        for (int i = 0; i < 5; i++) tick();

        // Misaligned target faults once and halts.
        redirect_to(64'h6);
        wait_valid("redir6", 8);
        check("redir6_inv", 64'(invAddr), 64'd1);
        check("redir6_pc", out_pc, 64'h6);
        check("redir6_instr", 64'(out_instr), 64'd0);
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        check("halt_quiet", 64'(seen), 64'd0);
        redirect_to(64'h0);
        wait_valid("resume", 8);
        check("resume_pc", out_pc, 64'h0);
        check("resume_inv", 64'(invAddr), 64'd0);

        // Redirect during an accepted handshake to an out-of-range target.
        redirect_to(64'h1000_0000_0000_0010);
        wait_valid("redir_hi", 8);
        check("hi_inv", 64'(invAddr), 64'd1);
        check("hi_pc", out_pc, 64'h1000_0000_0000_0010);
        tick();

        // Reset in the middle of a burst.
        redirect_to(64'h40);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_instr", 64'(out_instr), 64'd0);
        check("mid_rst_pc", out_pc, 64'd0);
        check("mid_rst_inv", 64'(invAddr), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_pc", out_pc, RESET_PC);

        // Run off the end of instruction memory.
        redirect_to(PC_LIMIT - 64'd16);
        seen = 0;
        while (!(out_valid === 1'b1 && invAddr === 1'b1) && seen < 30) begin
            tick();
            seen++;
        end
        check("end_fault_flag", 64'(invAddr), 64'd1);
        check("end_fault_pc", out_pc, PC_LIMIT);
        check("last_good_pc", last_pc, PC_LIMIT - 64'd4);
        tick();

        // Randomized traffic: back-pressure, redirects, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = PC_LIMIT - 64'(4 * $urandom_range(0, 6));
                2:       redirect_pc = 64'($urandom_range(0, 4095));
                default: redirect_pc = 64'($urandom_range(0, IMEM_DEPTH - 1)) * 64'd4;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("random_progress", 64'(accepted > 300), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
